fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage between the PC/redirect logic and inst_decode; replaces the combinational PC->inst_mem path with a handshaked fetch.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable response latency of one cycle or more.
- Buffers returned instructions together with their PCs in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Redirects (taken branch/jump, ALU_out when pc_sel=1) flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, instruction and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch queue entries (power of 2, >=2); also the max in-flight request count

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch address
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_rsp_valid  input  1  response beat, in request order
imem_rsp_data  input  32  instruction word
inst_valid  output  1  head instruction available to decode
inst_ready  input  1  decode consumes head
inst  output  32  head instruction
inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0. Reset mid-operation discards everything, with no flush cycle needed.
- Queue:
  - An entry is allocated at request acceptance (imem_req_valid&&imem_req_ready) and stores fetch_pc, with filled=0.
  - Each non-dropped response fills the oldest unfilled entry.
  - inst_valid = head allocated && filled; inst/inst_pc come from the head entry, registered with no combinational path from imem_rsp_*.
  - inst_ready&&inst_valid pops the head.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (allocated entries + drop_cnt) < DEPTH.
  - imem_req_addr = fetch_pc. On acceptance, fetch_pc += 4, wrapping modulo 2^XLEN.
  - imem_req_valid must not depend combinationally on imem_req_ready.
- Latency:
  - Minimum request-to-inst_valid latency is 2 cycles (response in cycle N+1 after acceptance in N, inst_valid in N+2).
  - Back-to-back sustained throughput is 1 instr/cycle when memory responds every cycle and decode is always ready.
- Redirect (redirect_valid=1 in cycle N):
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; misaligned low bits are dropped silently.
  - All queue entries are invalidated, including the head, even if popped the same cycle. The pop is ignored and inst_valid=0 in N+1.
  - drop_cnt <= number of unfilled allocated entries, minus 1 if imem_rsp_valid in N (that response is discarded).
  - No request is issued in cycle N. Fetch of the new path starts in N+1.
- Drop:
  - While drop_cnt>0, each imem_rsp_valid decrements drop_cnt and the data is discarded.
  - New-path requests may issue during drop, within credits. Responses stay in order, so no tag is needed.
- FSM for visibility and assertions:
  - States are RESET, FETCH and DRAIN; the state is derivable from drop_cnt.
  - RESET->FETCH on the first cycle after rst deasserts.
  - FETCH->DRAIN on a redirect with in-flight responses.
  - DRAIN->FETCH when drop_cnt hits 0.
  - A redirect while in DRAIN reloads drop_cnt = current drop_cnt + unfilled entries (minus any response arriving that cycle).
- Simultaneous events:
  - Push-fill and pop in the same cycle on a full queue are legal; fill and pop never target the same entry unless it is the head already filled.
  - A response with no unfilled entry and drop_cnt=0 is a protocol error; assert in simulation and ignore in RTL.
- Full/empty:
  - Queue full (DEPTH allocated) stalls requests only.
  - Empty queue gives inst_valid=0.
  - Pointers are log2(DEPTH)+1 bits, with the wrap bit distinguishing full from empty.

Decomposition:
- Shared package (riscv_pkg): XLEN, INST_W=32, RESET_PC default, NOP encoding 32'h0000_0013, fetch FSM state enum.
- One sub-module, fetch_queue: the DEPTH-entry ring with allocate/fill/pop/flush ports and separate alloc/fill/read pointers.
- fetch_unit holds fetch_pc, credit/drop counters and the FSM.

Test Plan:
1. Reset release, memory 1-cycle latency, decode always ready:
   - Required: requests to 0x0,0x4,0x8,… on consecutive cycles.
   - Required: inst_pc 0x0 with inst_valid two cycles after the first acceptance, then one instr per cycle.
2. Decode holds inst_ready=0 for 10 cycles:
   - Required: exactly DEPTH=4 requests accepted, then imem_req_valid=0.
   - Required: the head stays at inst_pc=0x0 with stable inst, and fetch resumes one request per pop.
3. Memory 3-cycle latency, 3 requests in flight, redirect to 0x100:
   - Required: the 3 stale responses are discarded.
   - Required: the first inst_valid shows inst_pc=0x100 with data from the 0x100 request.
4. Redirect with redirect_pc=0x103 coincident with a pop and a response:
   - Required: the next request address is 0x100 and the pop is ignored.
   - Required: the coincident response is dropped and drop_cnt is correct (no extra or missing discards).
5. Second redirect to 0x200 during DRAIN from a first redirect to 0x100:
   - Required: no instruction from 0x100 reaches decode unless fetched after the first redirect and before the second.
   - Required: output resumes at 0x200.
6. Assert rst mid-stream with requests in flight, deassert, then ignore stale responses via a memory model reset:
   - Required: restart at RESET_PC with all outputs 0 during reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path: widths, reset address, NOP encoding
// and the fetch FSM state type.
// Latency: n/a (definitions only). Backpressure: n/a.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // DRAIN means stale responses are still owed by memory and will be dropped.
  typedef enum logic [1:0] {
    FS_RESET = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch ring: entries are allocated at request time (PC), filled in order by
// responses (instruction) and popped from the head once filled.
// Latency: a fill becomes visible at the head on the next cycle. Backpressure:
// the owner must not allocate when full; pop is ignored unless the head is filled.
// Ports: flush_i clears all entries; alloc_i/alloc_pc_i push a PC; fill_i/fill_data_i
// complete the oldest unfilled entry; pop_i consumes the head; head_* present it;
// alloc_cnt_o / unfilled_cnt_o report occupancy.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [XLEN-1:0]   alloc_pc_i,
  input  logic              fill_i,
  input  logic [INST_W-1:0] fill_data_i,
  input  logic              pop_i,
  output logic              head_vld_o,
  output logic [INST_W-1:0] head_inst_o,
  output logic [XLEN-1:0]   head_pc_o,
  output logic [$clog2(DEPTH):0] alloc_cnt_o,
  output logic [$clog2(DEPTH):0] unfilled_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Extra MSB on each pointer separates full from empty.
  logic [PW-1:0]     alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic              fill_ok, pop_ok;

  // Fills are in order, so the head is filled exactly when fill_ptr has passed it.
  assign head_vld_o     = (rd_ptr_q != fill_ptr_q);
  assign fill_ok        = fill_i && !flush_i && (fill_ptr_q != alloc_ptr_q);
  assign pop_ok         = pop_i && head_vld_o;
  assign alloc_cnt_o    = alloc_ptr_q - rd_ptr_q;
  assign unfilled_cnt_o = alloc_ptr_q - fill_ptr_q;
  assign head_inst_o    = head_vld_o ? inst_q[rd_ptr_q[AW-1:0]] : '0;
  assign head_pc_o      = head_vld_o ? pc_q[rd_ptr_q[AW-1:0]]   : '0;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (alloc_i) alloc_ptr_q <= alloc_ptr_q + PW'(1);
      if (fill_ok) fill_ptr_q  <= fill_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q    <= rd_ptr_q + PW'(1);
    end
  end

  // Payload storage needs no reset: validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) pc_q[alloc_ptr_q[AW-1:0]] <= alloc_pc_i;
    if (fill_ok)             inst_q[fill_ptr_q[AW-1:0]] <= fill_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order memory requests within
// DEPTH credits, buffers responses and hands instructions to decode.
// Latency: 2 cycles request-accept to inst_valid; 1 instr/cycle sustained.
// Backpressure: decode stall fills the queue, which then holds imem_req_valid low.
// Ports: redirect_* restart fetch; imem_req_*/imem_rsp_* talk to instruction
// memory (responses in request order); inst_valid/inst_ready/inst/inst_pc feed decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEF),
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     drop_cnt_q, drop_cnt_d;
  fetch_state_e      state_q, state_d;

  logic [PW-1:0]     alloc_cnt, unfilled_cnt;
  logic [PW-1:0]     occupancy, drop_sum;
  logic              head_vld;
  logic [INST_W-1:0] head_inst;
  logic [XLEN-1:0]   head_pc;
  logic              req_fire, fill_en;
  logic              unused_pc_bits;

  // Misaligned redirect bits are dropped on purpose.
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Responses still owed for dropped requests consume credits just like live
  // entries, so memory never holds more than DEPTH outstanding requests.
  assign occupancy      = alloc_cnt + drop_cnt_q;
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < PW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fill_en        = imem_rsp_valid && (drop_cnt_q == '0);

  assign inst_valid = !rst && head_vld;
  assign inst       = inst_valid ? head_inst : '0;
  assign inst_pc    = inst_valid ? head_pc   : '0;

  fetch_queue #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (redirect_valid),
    .alloc_i       (req_fire),
    .alloc_pc_i    (fetch_pc_q),
    .fill_i        (fill_en),
    .fill_data_i   (imem_rsp_data),
    .pop_i         (inst_ready),
    .head_vld_o    (head_vld),
    .head_inst_o   (head_inst),
    .head_pc_o     (head_pc),
    .alloc_cnt_o   (alloc_cnt),
    .unfilled_cnt_o(unfilled_cnt)
  );

  // PC and drop counter next state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = drop_cnt_q + unfilled_cnt;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // A response this cycle either fills an entry being flushed or retires
      // an already-owed drop; either way it is one fewer to discard later.
      if (imem_rsp_valid && (drop_sum != '0)) drop_sum = drop_sum - PW'(1);
      drop_cnt_d = drop_sum;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - PW'(1);
    end
  end

  // FSM next state; DRAIN mirrors a non-zero drop counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_RESET: state_d = (drop_cnt_d != '0) ? FS_DRAIN : FS_FETCH;
      FS_FETCH: if (drop_cnt_d != '0) state_d = FS_DRAIN;
      FS_DRAIN: if (drop_cnt_d == '0) state_d = FS_FETCH;
      default:  state_d = FS_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      state_q    <= FS_RESET;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  // A response with nothing to fill and nothing owed is a memory protocol error.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_cnt_q != '0) || (unfilled_cnt != '0)));

  a_drain_state: assert property (@(posedge clk) disable iff (rst)
    (state_q == FS_DRAIN) == (drop_cnt_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int accepts = 0, pops = 0;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference model: after reset or redirect, decode must see the aligned
  // target followed by consecutive words, and memory must be asked for the same.
  logic [31:0] exp_q[$];
  logic [31:0] exp_req = RST_PC;

  task automatic seg_start(logic [31:0] target);
    logic [31:0] p;
    p = {target[31:2], 2'b00};
    exp_q.delete();
    exp_req = p;
    for (int i = 0; i < 2048; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Memory model: in-order, per-request latency in [lat_min, lat_max].
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int lat_min = 1, lat_max = 1;
  bit mem_rand_rdy = 0;

  initial begin : memory
    pend_t pe;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      imem_req_ready = mem_rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
      @(negedge clk);
      if (rst) pend.delete();
      else if (imem_req_valid && imem_req_ready) begin
        pe.addr = imem_req_addr;
        pe.due  = cyc + int'($urandom_range(lat_min, lat_max));
        pend.push_back(pe);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT hands over a request or an instruction.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (redirect_valid) check32("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
          accepts++;
          check32("req_addr", imem_req_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow: got inst_pc 0x%08h expected nothing", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check32("inst_pc", inst_pc, e);
            check32("inst_data", inst, mem_word(e));
          end
        end
      end
    end
  end

  task automatic step();      @(posedge clk); #2; endtask
  task automatic at_sample(); @(negedge clk); #1; endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    seg_start(RST_PC);
    repeat (n) begin
      step();
      at_sample();
      check32("rst_req_valid",  32'(imem_req_valid), 32'd0);
      check32("rst_inst_valid", 32'(inst_valid), 32'd0);
      check32("rst_inst",       inst, 32'd0);
      check32("rst_inst_pc",    inst_pc, 32'd0);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic do_redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    seg_start(pc);
    step();
    redirect_valid = 1'b0;
    at_sample();
    check32("valid_after_redirect", 32'(inst_valid), 32'd0);
    step();
  endtask

  task automatic wait_valid(string name, logic [31:0] exp_pc);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_sample();
      if (inst_valid) begin
        found = 1;
        check32(name, inst_pc, exp_pc);
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL %s: got no inst_valid within 40 cycles, required inst_pc 0x%08h", name, exp_pc);
    end
    step();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stimulus
    int a, v, a0, p0, bad, r, sel;
    logic [31:0] vpc, rp;
    bit hit;

    step();
    // 1: reset release, 1-cycle memory, decode always ready.
    do_reset(3);
    a = -1; v = -1; vpc = '1;
    for (int i = 0; i < 30; i++) begin
      at_sample();
      if (a < 0 && imem_req_valid && imem_req_ready) a = cyc;
      if (v < 0 && inst_valid) begin v = cyc; vpc = inst_pc; end
    end
    check32("t1_first_latency", 32'(v - a), 32'd2);
    check32("t1_first_pc", vpc, RST_PC);
    a0 = accepts; p0 = pops;
    repeat (20) at_sample();
    check32("t1_pop_rate", 32'(pops - p0), 32'd20);
    check32("t1_req_rate", 32'(accepts - a0), 32'd20);
    step();

    // 2: decode stalls for a while after reset.
    inst_ready = 1'b0;
    do_reset(2);
    a0 = accepts; bad = 0;
    repeat (12) begin
      at_sample();
      if (inst_valid && (inst_pc !== RST_PC || inst !== mem_word(RST_PC))) bad++;
    end
    check32("t2_accepts_full", 32'(accepts - a0), 32'(DEPTH));
    check32("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
    check32("t2_head_valid", 32'(inst_valid), 32'd1);
    check32("t2_head_pc", inst_pc, RST_PC);
    check32("t2_head_inst", inst, mem_word(RST_PC));
    check32("t2_head_stable", 32'(bad), 32'd0);
    step();
    inst_ready = 1'b1;
    a0 = accepts; p0 = pops;
    repeat (8) at_sample();
    check32("t2_resume_pops", 32'(pops - p0), 32'd8);
    check32("t2_resume_reqs", 32'(accepts - a0), 32'd7);
    step();
    repeat (10) step();

    // 3: 3-cycle memory, redirect with responses in flight.
    lat_min = 3; lat_max = 3;
    repeat (12) step();
    do_redirect(32'h100);
    wait_valid("t3_first_pc", 32'h100);
    repeat (15) step();

    // 4: redirect to a misaligned target on a cycle with a pop and a response.
    lat_min = 1; lat_max = 1;
    repeat (10) step();
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (inst_valid && imem_rsp_valid && inst_ready) hit = 1;
    end
    check32("t4_coincident_found", 32'(hit), 32'd1);
    do_redirect(32'h103);
    wait_valid("t4_first_pc", 32'h100);
    repeat (15) step();

    // 5: second redirect while still draining from the first.
    lat_min = 4; lat_max = 4;
    repeat (10) step();
    do_redirect(32'h100);
    do_redirect(32'h200);
    wait_valid("t5_first_pc", 32'h200);
    repeat (20) step();

    // 6: reset mid-stream with requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (10) step();
    do_reset(2);
    wait_valid("t6_restart_pc", RST_PC);
    repeat (10) step();

    // Randomized phase: random latency, memory and decode backpressure, redirects, resets.
    lat_min = 1; lat_max = 5; mem_rand_rdy = 1;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 999));
      if (r < 30) begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else if (sel == 1) rp = 32'($urandom_range(0, 4095));
        else               rp = $urandom;
        do_redirect(rp);
      end else if (r < 33) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        step();
      end
    end
    mem_rand_rdy = 0; inst_ready = 1'b1;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
